// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler: round-robin arbiter that frames requester words
// as header + payload bytes onto a single UART TX byte stream.
module uart_frame_scheduler #(
  parameter int          NUM_REQ  = 4,
  parameter int          DATA_W   = 16,
  parameter logic [7:0]  HDR_BASE = 8'hA0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic [7:0]                overrun_cnt
);

  localparam int NB    = DATA_W / 8;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BI_W  = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant_q;
  logic [DATA_W-1:0] word_q;
  logic [BI_W-1:0]   byte_idx;

  logic              found;
  logic [PTR_W-1:0]  gsel;
  logic [PTR_W:0]    cand;
  logic              hs;
  logic              last_hs;
  logic              take;
  logic [PTR_W-1:0]  rr_nxt;

  assign hs      = tx_valid & tx_ready;
  assign last_hs = (state == DATA) && hs && (byte_idx == '0);
  assign take    = (state == IDLE) && tick && found;

  // pointer to the requester after the one just served, wrapping
  assign rr_nxt = (grant_q == PTR_W'(NUM_REQ - 1))
                ? '0
                : grant_q + PTR_W'(1);

  // first pending requester at or after rr_ptr, wrapping at NUM_REQ
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ))
        cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!found && req_valid[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        gsel  = cand[PTR_W-1:0];
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (take)
          state_nxt = HDR;
      end
      HDR: begin
        if (hs)
          state_nxt = DATA;
      end
      DATA: begin
        if (last_hs)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // output decode: byte on the wire follows state and byte index
  always_comb begin
    tx_valid = 1'b0;
    busy     = 1'b0;
    tx_data  = 8'h00;
    unique case (state)
      IDLE: begin
        tx_data = 8'h00;
      end
      HDR: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = HDR_BASE | 8'(grant_q);
      end
      DATA: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = word_q[byte_idx*8 +: 8];
      end
      default: begin
        tx_data = 8'h00;
      end
    endcase
  end

  // grant latch, ack pulse, byte index and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      grant_q  <= '0;
      word_q   <= '0;
      byte_idx <= '0;
      req_ack  <= '0;
    end else begin
      req_ack <= '0;
      if (take) begin
        grant_q <= gsel;
        word_q  <= req_data[gsel*DATA_W +: DATA_W];
        req_ack <= NUM_REQ'(1) << gsel;
      end
      if ((state == HDR) && hs)
        byte_idx <= BI_W'(NB - 1);
      if ((state == DATA) && hs) begin
        if (byte_idx == '0)
          rr_ptr <= rr_nxt;
        else
          byte_idx <= byte_idx - BI_W'(1);
      end
    end
  end

  // ticks that land while a frame is in flight are lost and counted
  always_ff @(posedge clk) begin
    if (rst)
      overrun_cnt <= 8'h00;
    else if (tick && (state != IDLE) && (overrun_cnt != 8'hFF))
      overrun_cnt <= overrun_cnt + 8'h01;
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb_uart_frame_scheduler: directed + random checks against a
// transaction-level model built from a byte queue.
module tb_uart_frame_scheduler;

  localparam int         NREQ = 4;
  localparam int         DW   = 16;
  localparam int         NB   = DW / 8;
  localparam logic [7:0] HDR  = 8'hA0;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic [7:0]        overrun_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]      pend[$];
  int              m_rr;
  int              m_ovr;
  int              m_grant;
  logic [NREQ-1:0] m_ack;

  uart_frame_scheduler #(
    .NUM_REQ (NREQ),
    .DATA_W  (DW),
    .HDR_BASE(HDR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [NREQ-1:0] nack;
    bit              hit;
    nack = '0;
    hit  = 0;
    if (rst) begin
      pend.delete();
      m_rr  = 0;
      m_ovr = 0;
      m_ack = '0;
      return;
    end
    if (pend.size() > 0) begin
      if (tick && m_ovr < 255)
        m_ovr++;
      if (tx_ready) begin
        void'(pend.pop_front());
        if (pend.size() == 0)
          m_rr = (m_grant + 1) % NREQ;
      end
    end else if (tick && req_valid != 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!hit && req_valid[(m_rr + k) % NREQ]) begin
          m_grant = (m_rr + k) % NREQ;
          hit     = 1;
        end
      end
      pend.push_back(HDR | 8'(m_grant));
      for (int b = NB - 1; b >= 0; b--)
        pend.push_back(req_data[m_grant*DW + b*8 +: 8]);
      nack[m_grant] = 1'b1;
    end
    m_ack = nack;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("ack", 32'(req_ack), 32'(m_ack));
    chk("valid", 32'(tx_valid), 32'(pend.size() != 0));
    chk("busy", 32'(busy), 32'(pend.size() != 0));
    chk("ovr", 32'(overrun_cnt), 32'(m_ovr));
    if (pend.size() != 0)
      chk("data", 32'(tx_data), 32'(pend[0]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_data", 32'(tx_data), 32'h0);
  endtask

  task automatic tick_step();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    tick      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    step();
    do_reset();
    chk("rst_valid", 32'(tx_valid), 32'h0);
    chk("rst_ovr", 32'(overrun_cnt), 32'h0);

    // single frame, requester 2
    req_valid = 4'b0100;
    req_data  = {16'h0, 16'h1234, 16'h0, 16'h0};
    tick_step();
    chk("t1_ack", 32'(req_ack), 32'h4);
    chk("t1_hdr", 32'(tx_data), 32'hA2);
    req_data = '1;
    step();
    chk("t1_b1", 32'(tx_data), 32'h12);
    step();
    chk("t1_b0", 32'(tx_data), 32'h34);
    step();
    chk("t1_idle", 32'(busy), 32'h0);

    // round-robin rotation with all requesters pending
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      req_data = {$urandom, $urandom};
      tick_step();
      chk("t2_hdr", 32'(tx_data), 32'(HDR | 8'(i % NREQ)));
      repeat (9) step();
    end

    // backpressure on header, then toggling ready
    do_reset();
    req_valid = 4'b0001;
    req_data  = {$urandom, $urandom};
    tx_ready  = 1'b0;
    tick_step();
    repeat (5) step();
    chk("t3_hold", 32'(tx_data), 32'hA0);
    for (int i = 0; i < 8; i++) begin
      tx_ready = ~tx_ready;
      step();
    end
    tx_ready = 1'b1;
    repeat (3) step();
    chk("t3_done", 32'(busy), 32'h0);

    // overruns: mid-frame, coincident with last byte, saturation
    do_reset();
    req_valid = 4'b0001;
    tick_step();
    tick_step();
    chk("t4_ovr1", 32'(overrun_cnt), 32'h1);
    step();
    tick_step();
    chk("t4_ovr2", 32'(overrun_cnt), 32'h2);
    chk("t4_idle", 32'(busy), 32'h0);
    step();
    tx_ready = 1'b0;
    tick_step();
    for (int i = 0; i < 300; i++) begin
      tick_step();
      step();
    end
    chk("t4_sat", 32'(overrun_cnt), 32'hFF);
    tx_ready = 1'b1;

    // reset mid-frame clears pointer and aborts the frame
    do_reset();
    req_valid = 4'b0001;
    tick_step();
    repeat (3) step();
    req_valid = 4'b0010;
    tick_step();
    chk("t5_hdr1", 32'(tx_data), 32'hA1);
    step();
    do_reset();
    chk("t5_valid", 32'(tx_valid), 32'h0);
    req_valid = 4'b0011;
    tick_step();
    chk("t5_hdr0", 32'(tx_data), 32'hA0);
    repeat (3) step();

    // tick with nothing pending
    req_valid = '0;
    tick_step();
    chk("t6_ack", 32'(req_ack), 32'h0);
    chk("t6_valid", 32'(tx_valid), 32'h0);
    chk("t6_ovr", 32'(overrun_cnt), 32'h0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      tick      = ($urandom_range(0, 5) == 0);
      tx_ready  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0)
        req_valid = 4'($urandom);
      req_data  = {$urandom, $urandom};
      step();
    end
    rst  = 1'b0;
    tick = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
